dvi_timing_gen: RTL
===================

Name: dvi_timing_gen

Overview:
- Raster timing generator for the DVI pipeline, directly upstream of the pixel generator.
- Produces the free-running pixel coordinates x_o/y_o that feed the pixel generator's x/y inputs.
- Produces the hsync/vsync/data-enable that travel alongside the pixel colours into the TMDS encoders.
- Sync/DE are delayed by a parameterised number of cycles so they stay aligned with pixel colour, which arrives PIPE_DLY cycles after its coordinate.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync active level (0 = active-low)
V_SYNC_POL, 0, vsync active level (0 = active-low)
PIPE_DLY, 2, downstream coordinate-to-colour latency in clocks, range 0..15

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  reset; one clock, asynchronous active-low reset
- en_i  in  1  clock enable; low freezes the entire block
- x_o  out  X_POS_W  horizontal counter, 0..H_TOTAL-1
- y_o  out  Y_POS_W  vertical counter, 0..V_TOTAL-1
- hsync_o  out  1  horizontal sync, delayed PIPE_DLY
- vsync_o  out  1  vertical sync, delayed PIPE_DLY
- de_o  out  1  data enable, delayed PIPE_DLY
- frame_start_o  out  1  one-clock pulse, delayed PIPE_DLY

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
  - X_POS_W/Y_POS_W come from dvi_pkg and must hold H_TOTAL-1 and V_TOTAL-1; elaboration fails otherwise.
- Reset (asynchronous, rst_ni low):
  - x_o = 0, y_o = 0.
  - hsync_o = ~H_SYNC_POL, vsync_o = ~V_SYNC_POL.
  - de_o = 0, frame_start_o = 0.
  - Every delay-pipeline stage is loaded with these same inactive values.
- Counters (registered, advance only when en_i = 1):
  - x increments each clock; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps to 0 when x wraps and y = V_TOTAL-1.
  - No other wrap points exist.
- Line layout: active [0, H_ACTIVE), then front porch, then sync, then back porch.
- Raw (undelayed) signals, computed from the current counter values:
  - hs_raw active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. vsync therefore toggles only at x = 0.
  - de_raw = (x < H_ACTIVE) && (y < V_ACTIVE).
  - fs_raw = (x == 0) && (y == 0).
- Polarity: output level = raw XOR inactive level, i.e. asserted = H_SYNC_POL / V_SYNC_POL.
- Delay:
  - Outputs equal the raw signals for the coordinate presented on x_o/y_o exactly PIPE_DLY enabled clocks earlier.
  - PIPE_DLY = 0: outputs are combinational from the counter registers, aligned with x_o/y_o.
  - Delay line is a shift register of PIPE_DLY stages; it shifts only when en_i = 1.
- en_i low: counters, delay line and all outputs hold their values. No pulse is generated or stretched, except that frame_start_o holds its current level.
- Reset mid-frame: immediate return to the reset state; the raster restarts at (0,0) on the first enabled clock after release.
- The first PIPE_DLY enabled clocks after reset output the inactive pipeline contents (de_o = 0); there are no spurious sync pulses.

Test Plan:
- Reset release, en_i=1, defaults:
  - x_o reads 0,1,2… from the first clock; y_o = 0.
  - de_o first rises 2 clocks after x_o=0, stays high 640 clocks, low 160.
- Horizontal sync: hsync_o low for exactly 96 clocks; the falling edge occurs 2 clocks after x_o = 656; period 800 clocks.
- Vertical sync:
  - vsync_o low for exactly 2×800 clocks; it asserts 2 clocks after (x_o, y_o) = (0, 490).
  - Frame period 420000 clocks; de_o high for 640×480 clocks per frame.
- Wrap: at (x_o, y_o) = (799, 524), the next clock gives (0, 0); frame_start_o pulses once, 2 clocks later, width 1.
- en_i deasserted for 5 clocks mid-line at x_o = 100: all outputs are frozen; after resumption de_o still totals 640 clocks for that line.
- Reset asserted mid-vsync: outputs go to hsync_o = vsync_o = 1, de_o = 0 within the same cycle, with no clock edge needed. Rerun with PIPE_DLY=0: de_o rises in the same cycle x_o = 0.

Source files
------------

// File: rtl/dvi_timing_gen.sv
// Raster timing generator for the DVI pipeline.
// Free-running x/y pixel coordinates feed the pixel generator. The matching
// hsync/vsync/de/frame_start are delayed by PIPE_DLY enabled clocks so that
// they line up with the colour the pixel generator returns for that coordinate.

package dvi_pkg;
    // Coordinate widths shared with the pixel generator.
    localparam int X_POS_W = 10;
    localparam int Y_POS_W = 10;

    // Sync bundle, carried at output polarity.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic fs;
    } sync_t;
endpackage

module dvi_timing_gen
    import dvi_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIPE_DLY   = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    output logic [X_POS_W-1:0] x_o,
    output logic [Y_POS_W-1:0] y_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic               frame_start_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [X_POS_W-1:0] X_LAST = X_POS_W'(H_TOTAL - 1);
    localparam logic [Y_POS_W-1:0] Y_LAST = Y_POS_W'(V_TOTAL - 1);

    // Inactive levels: what reset presents and what fills the delay line.
    localparam sync_t SYNC_IDLE = '{hsync: ~H_SYNC_POL, vsync: ~V_SYNC_POL, de: 1'b0, fs: 1'b0};

    // Refuse to build a raster the coordinate ports cannot represent.
    if (H_TOTAL - 1 >= (1 << X_POS_W)) begin : g_chk_x_w
        $error("dvi_timing_gen: H_TOTAL-1 does not fit in X_POS_W");
    end
    if (V_TOTAL - 1 >= (1 << Y_POS_W)) begin : g_chk_y_w
        $error("dvi_timing_gen: V_TOTAL-1 does not fit in Y_POS_W");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_chk_dly
        $error("dvi_timing_gen: PIPE_DLY must be in 0..15");
    end

    logic [X_POS_W-1:0] x_q;
    logic [Y_POS_W-1:0] y_q;
    sync_t              sync_cur;
    sync_t              sync_out;

    // Raster counters: x sweeps the line, y advances when x wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en_i) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    // Decode sync/de/frame-start for the current coordinate at output polarity.
    always_comb begin
        // NOTE: defaults first so every path assigns sync_cur and no latch is inferred.
        sync_cur = SYNC_IDLE;
        if (int'(x_q) >= HS_START && int'(x_q) < HS_END) begin
            sync_cur.hsync = H_SYNC_POL;
        end
        if (int'(y_q) >= VS_START && int'(y_q) < VS_END) begin
            sync_cur.vsync = V_SYNC_POL;
        end
        sync_cur.de = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
        sync_cur.fs = (x_q == '0) && (y_q == '0);
    end

    if (PIPE_DLY == 0) begin : g_no_dly
        // No delay line: decoded straight from the counters, forced idle in reset
        // because the reset coordinate (0,0) would otherwise decode as active.
        assign sync_out = rst_ni ? sync_cur : SYNC_IDLE;
    end else begin : g_dly
        sync_t pipe_q [PIPE_DLY];

        // Delay line: shifts on enabled clocks only, so it freezes with the counters.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                // NOTE: this is a handful of flops, not RAM, so every stage is reset
                // to idle; that is what keeps the first PIPE_DLY outputs pulse-free.
                for (int i = 0; i < PIPE_DLY; i++) begin
                    pipe_q[i] <= SYNC_IDLE;
                end
            end else if (en_i) begin
                pipe_q[0] <= sync_cur;
                for (int i = 1; i < PIPE_DLY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign sync_out = pipe_q[PIPE_DLY-1];
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign hsync_o       = sync_out.hsync;
    assign vsync_o       = sync_out.vsync;
    assign de_o          = sync_out.de;
    assign frame_start_o = sync_out.fs;

endmodule
